wb_arbiter: RTL

Writeback arbiter directly upstream of the integer register file's single write port. It merges ALU/CSR results from the execute unit with load data returned by the load/store unit. It sign- or zero-extends and aligns load data, buffers execute results in a 2-entry FIFO, and drives a registered write (wen/waddr/wdata) into the register file. Load responses have priority, with a starvation guard for execute results.

---
 rtl/wb_arbiter_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 56 +++++
 rtl/wb_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter_pkg
//  Purpose  : Shared definitions for the writeback arbiter: load funct3
//             encodings and the default register index / data widths.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 5;
   localparam int unsigned DEF_DATA_WIDTH = 32;

   localparam logic [2:0] LOAD_LB  = 3'd0;
   localparam logic [2:0] LOAD_LH  = 3'd1;
   localparam logic [2:0] LOAD_LW  = 3'd2;
   localparam logic [2:0] LOAD_LBU = 3'd4;
   localparam logic [2:0] LOAD_LHU = 3'd5;

endpackage : wb_arbiter_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fifo
//  Purpose  : Small synchronous FIFO with asynchronous reset. Exposes the
//             head entry combinationally and the current occupancy.
//  Ports    : clk, rst        - clock, async active-high reset
//             push_i, wdata_i - write strobe and entry (caller ensures room)
//             pop_i           - read strobe (caller ensures non-empty)
//             head_o          - oldest entry
//             count_o         - number of valid entries (0..DEPTH)
//  Revision : 1.0 - initial release
// ============================================================================
module wb_fifo #(
   parameter int unsigned WIDTH = 37,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;

   // DEPTH is a power of two, so pointers wrap naturally on overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Writeback arbiter in front of the register-file write port.
//             Buffers execute results in a FIFO, extends/aligns load data,
//             gives loads priority with a starvation guard for execute
//             results, and registers the single write (wen/waddr/wdata).
//  Ports    : clk, rst                         - clock, async active-high reset
//             exu_valid_i/exu_ready_o/exu_rd_i/exu_wdata_i - execute results
//             lsu_valid_i/lsu_ready_o/lsu_rd_i/lsu_funct3_i/
//             lsu_addr_lo_i/lsu_rdata_i        - load responses
//             rf_wen_o/rf_waddr_o/rf_wdata_o   - registered RF write
//             rs1_raddr_i/rs2_raddr_i, byp_rs*_hit_o/byp_rs*_data_o
//                                              - forwarding (optional)
//  Config   : WB_ARBITER_BYPASS_EN - when defined, adds the combinational
//             forwarding ports for the value in flight to the register file.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  exu_valid_i,
   output logic                  exu_ready_o,
   input  logic [ADDR_WIDTH-1:0] exu_rd_i,
   input  logic [DATA_WIDTH-1:0] exu_wdata_i,
   input  logic                  lsu_valid_i,
   output logic                  lsu_ready_o,
   input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
   input  logic [2:0]            lsu_funct3_i,
   input  logic [1:0]            lsu_addr_lo_i,
   input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
`ifdef WB_ARBITER_BYPASS_EN
   input  logic [ADDR_WIDTH-1:0] rs1_raddr_i,
   input  logic [ADDR_WIDTH-1:0] rs2_raddr_i,
   output logic                  byp_rs1_hit_o,
   output logic [DATA_WIDTH-1:0] byp_rs1_data_o,
   output logic                  byp_rs2_hit_o,
   output logic [DATA_WIDTH-1:0] byp_rs2_data_o,
`endif
   output logic                  rf_wen_o,
   output logic [ADDR_WIDTH-1:0] rf_waddr_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_o
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
   localparam int unsigned ENT_W = ADDR_WIDTH + DATA_WIDTH;

   logic [CNT_W-1:0]      fifo_count;
   logic [ENT_W-1:0]      fifo_head;
   logic                  fifo_nonempty;
   logic                  fifo_push;
   logic                  starve_hit;
   logic                  grant_exu;
   logic                  grant_lsu;
   logic [STV_W-1:0]      starve_q, starve_d;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] ld_data;
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  wen_q, wen_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   // ------------------------------------------------------------------
   // Execute-result buffer. Readiness looks at occupancy only, so a pop
   // in the same cycle never makes room for a push.
   // ------------------------------------------------------------------
   assign exu_ready_o = (fifo_count < CNT_W'(FIFO_DEPTH));
   assign fifo_push   = exu_valid_i && exu_ready_o;

   wb_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .wdata_i ({exu_rd_i, exu_wdata_i}),
      .pop_i   (grant_exu),
      .head_o  (fifo_head),
      .count_o (fifo_count)
   );

   assign fifo_nonempty = (fifo_count != '0);

   // ------------------------------------------------------------------
   // Arbitration: loads win unless an execute result has waited through
   // STARVE_MAX load grants, in which case the load is refused once.
   // ------------------------------------------------------------------
   assign starve_hit  = (starve_q == STV_W'(STARVE_MAX));
   assign grant_exu   = fifo_nonempty && (!lsu_valid_i || starve_hit);
   assign grant_lsu   = lsu_valid_i && !grant_exu;
   assign lsu_ready_o = !(fifo_nonempty && starve_hit);

   always_comb begin
      starve_d = starve_q;
      if (grant_exu || !fifo_nonempty) begin
         starve_d = '0;
      end else if (grant_lsu && !starve_hit) begin
         starve_d = starve_q + STV_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Load extension: byte lane picked by the full offset, half lane by
   // offset bit 1. Unlisted funct3 codes fall through to a full word.
   // ------------------------------------------------------------------
   assign ld_byte = lsu_rdata_i[{lsu_addr_lo_i, 3'b000} +: 8];
   assign ld_half = lsu_rdata_i[{lsu_addr_lo_i[1], 4'b0000} +: 16];

   always_comb begin
      ld_data = lsu_rdata_i;
      case (lsu_funct3_i)
         LOAD_LB:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
         LOAD_LH:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
         LOAD_LBU: ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
         LOAD_LHU: ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
         default:  ld_data = lsu_rdata_i;
      endcase
   end

   // ------------------------------------------------------------------
   // Output register. A grant to x0 is consumed without a write, and the
   // address/data hold so the RF sees no spurious change.
   // ------------------------------------------------------------------
   always_comb begin
      sel_rd   = grant_exu ? fifo_head[ENT_W-1 -: ADDR_WIDTH] : lsu_rd_i;
      sel_data = grant_exu ? fifo_head[DATA_WIDTH-1:0]        : ld_data;
      wen_d    = (grant_exu || grant_lsu) && (sel_rd != '0);
      waddr_d  = wen_d ? sel_rd   : waddr_q;
      wdata_d  = wen_d ? sel_data : wdata_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         starve_q <= starve_d;
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign rf_wen_o   = wen_q;
   assign rf_waddr_o = waddr_q;
   assign rf_wdata_o = wdata_q;

`ifdef WB_ARBITER_BYPASS_EN
   // Forward the write that the register file has not yet absorbed.
   assign byp_rs1_hit_o  = wen_q && (waddr_q == rs1_raddr_i) && (rs1_raddr_i != '0);
   assign byp_rs2_hit_o  = wen_q && (waddr_q == rs2_raddr_i) && (rs2_raddr_i != '0);
   assign byp_rs1_data_o = wdata_q;
   assign byp_rs2_data_o = wdata_q;
`endif

endmodule : wb_arbiter
`default_nettype wire
